pilot_ins: RTL
==============

PILOT_INS -- requirements
Module: pilot_ins

Interface
- REQ-001 Parameter NFFT, default 2048: subcarriers per OFDM symbol.
- REQ-002 Parameter NPILOT, default 128: pilots expected per symbol.
- REQ-003 Parameter PILOT_AMP, default 16'h2000: pilot magnitude, Q3.13 (1.0).
- REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
- REQ-005 rst  input  1  reset, asynchronous, active-low (asserted when 0).
- REQ-006 start  input  1  one-cycle pulse that begins one symbol.
- REQ-007 datin_val  input  1  datin_Re/datin_Im hold a valid data subcarrier.
- REQ-008 datin_Re, datin_Im  input  16 each  data subcarrier, Q3.13 two's complement.
- REQ-009 datin_rdy  output  1  data word consumed this cycle when datin_val is also high.
- REQ-010 car_idx  output  log2(NFFT)  index of the subcarrier currently being built.
- REQ-011 alloc_vec  input  2  allocation for car_idx, same cycle: 00 data, 01 positive pilot, 10 negative pilot, 11 null.
- REQ-012 datout_Re, datout_Im  output  16 each  subcarrier to IFFT, Q3.13.
- REQ-013 datout_val  output  1  datout holds a valid subcarrier.
- REQ-014 datout_rdy  input  1  downstream accepts datout this cycle.
- REQ-015 sym_done  output  1  one-cycle pulse after the last subcarrier is accepted.
- REQ-016 pil_err  output  1  pilot count of the finished symbol differed from NPILOT; valid with sym_done.

Function
- REQ-017 FSM states IDLE, RUN, DONE; IDLE->RUN on start, car_idx cleared to 0, pilot counter cleared.
- REQ-018 start in RUN or DONE SHALL be ignored.
- REQ-019 Output register is free when datout_val=0 or datout_rdy=1; a subcarrier is emitted only in RUN with the register free.
- REQ-020 alloc 00: emit only when datin_val=1; datout = datin; datin_rdy = RUN & free & alloc 00, combinational.
- REQ-021 alloc 01: datout_Re = +PILOT_AMP, 10: datout_Re = -PILOT_AMP (two's complement); datout_Im = 0; no data consumed; pilot counter +1.
- REQ-022 alloc 11: datout = 0, no data consumed.
- REQ-023 Latency: emitted subcarrier appears on datout one cycle after its car_idx cycle; datout held stable while datout_val=1 and datout_rdy=0.
- REQ-024 car_idx increments per emitted subcarrier; no wrap: emitting index NFFT-1 moves RUN->DONE.
- REQ-025 DONE waits until the last word is accepted, pulses sym_done one cycle, sets pil_err = (pilot count != NPILOT), then ->IDLE.
- REQ-026 Pilot counter is log2(NFFT)+1 bits wide and never saturates or wraps within a symbol.
- REQ-027 datin_rdy SHALL be 0 in IDLE and DONE.

Reset
- REQ-028 On rst=0: state IDLE, car_idx 0, datout_Re/Im 0, datout_val 0, sym_done 0, pil_err 0, pilot counter 0, PN register seed; immediate, without clk.
- REQ-029 Reset mid-symbol abandons the symbol; no sym_done is produced for it.

Configuration
- REQ-030 Macro PILOT_PN_EN defined: an 11-bit LFSR (x^11+x^9+1), seeded 11'h7FF at each start, advances once per emitted pilot; pilot sign = alloc sign XOR LFSR output bit.
- REQ-031 PILOT_PN_EN undefined: no LFSR present; pilot sign from alloc_vec only.

Verification
- REQ-032 Reset, then NFFT=8, alloc 00,01,00,10,11,00,01,00, datin 1..5 always valid, datout_rdy=1 -> datout_Re 1,+2000h,2,E000h,0,3,+2000h,4; sym_done on the cycle after the last word; pil_err=1 with NPILOT=128.
- REQ-033 Same stimulus, datout_rdy low for 3 cycles mid-symbol -> datout held constant, car_idx frozen, no data lost or duplicated.
- REQ-034 datin_val low on a data carrier -> no emission, car_idx held; pilot carriers never wait on datin_val.
- REQ-035 NFFT=2048, NPILOT=128, exactly 128 pilots -> sym_done with pil_err=0; start pulsed during RUN ignored.
- REQ-036 rst=0 asynchronously at car_idx 5 -> all outputs 0 before next edge; fresh start restarts at car_idx 0.
- REQ-037 With PILOT_PN_EN, all-positive pilots -> pilot signs match the LFSR sequence from seed 7FFh, reseeded per symbol.

Source files
------------

// File: rtl/pilot_ins.sv
// Pilot inserter: builds one OFDM symbol of NFFT subcarriers from data, +/- pilots and nulls.
// Latency: a subcarrier appears on datout one cycle after its car_idx cycle.
// Backpressure: output register stalls on datout_rdy=0; data carriers also wait on datin_val.
// Optional PILOT_PN_EN: pilot signs are scrambled by an 11-bit LFSR (x^11+x^9+1), seeded per symbol.
module pilot_ins #(
  parameter int          NFFT      = 2048,
  parameter int          NPILOT    = 128,
  parameter logic [15:0] PILOT_AMP = 16'h2000,
  localparam int         IW        = $clog2(NFFT),
  localparam int         CW        = IW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          datin_val,
  input  logic [15:0]   datin_Re,
  input  logic [15:0]   datin_Im,
  output logic          datin_rdy,
  output logic [IW-1:0] car_idx,
  input  logic [1:0]    alloc_vec,
  output logic [15:0]   datout_Re,
  output logic [15:0]   datout_Im,
  output logic          datout_val,
  input  logic          datout_rdy,
  output logic          sym_done,
  output logic          pil_err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [15:0] PILOT_NEG = ~PILOT_AMP + 16'd1;

  state_t        state_q, state_d;
  logic          done_d;
  logic [CW-1:0] pil_cnt;
  logic          out_free;
  logic          is_data;
  logic          is_pilot;
  logic          emit;
  logic          last_car;
  logic          pil_neg;
  logic          start_sym;

  // Handshake decode: the output register can take a new word when empty or being drained.
  always_comb begin
    out_free  = !datout_val || datout_rdy;
    is_data   = (alloc_vec == 2'b00);
    is_pilot  = (alloc_vec == 2'b01) || (alloc_vec == 2'b10);
    last_car  = (car_idx == IW'(NFFT - 1));
    start_sym = (state_q == IDLE) && start;
    emit      = (state_q == RUN) && out_free && (!is_data || datin_val);
    datin_rdy = (state_q == RUN) && out_free && is_data;
  end

`ifdef PILOT_PN_EN
  logic [10:0] lfsr_q;

  // Scrambler advances once per emitted pilot and restarts from all-ones at every symbol.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= 11'h7FF;
    end else if (start_sym) begin
      lfsr_q <= 11'h7FF;
    end else if (emit && is_pilot) begin
      lfsr_q <= {lfsr_q[9:0], lfsr_q[10] ^ lfsr_q[8]};
    end
  end

  // Pilot sign is the allocated sign flipped by the current scrambler bit.
  always_comb begin
    pil_neg = (alloc_vec == 2'b10) ^ lfsr_q[10];
  end
`else
  // Pilot sign comes straight from the allocation.
  always_comb begin
    pil_neg = (alloc_vec == 2'b10);
  end
`endif

  // Symbol sequencing: IDLE waits for start, RUN walks the carriers, DONE drains the last word.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (emit && last_car) state_d = DONE;
      DONE: begin
        if (out_free) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Output register: load on emit, otherwise hold until the consumer takes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      datout_Re  <= 16'd0;
      datout_Im  <= 16'd0;
      datout_val <= 1'b0;
    end else if (emit) begin
      datout_val <= 1'b1;
      case (alloc_vec)
        2'b00: begin
          datout_Re <= datin_Re;
          datout_Im <= datin_Im;
        end
        2'b01, 2'b10: begin
          datout_Re <= pil_neg ? PILOT_NEG : PILOT_AMP;
          datout_Im <= 16'd0;
        end
        default: begin
          datout_Re <= 16'd0;
          datout_Im <= 16'd0;
        end
      endcase
    end else if (datout_rdy) begin
      datout_val <= 1'b0;
    end
  end

  // Carrier index and pilot tally; the index parks on the last carrier rather than wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      car_idx <= '0;
      pil_cnt <= '0;
    end else if (start_sym) begin
      car_idx <= '0;
      pil_cnt <= '0;
    end else if (emit) begin
      if (!last_car) car_idx <= car_idx + IW'(1);
      if (is_pilot)  pil_cnt <= pil_cnt + CW'(1);
    end
  end

  // End-of-symbol pulse; pil_err holds its verdict until the next symbol completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sym_done <= 1'b0;
      pil_err  <= 1'b0;
    end else begin
      sym_done <= done_d;
      if (done_d) pil_err <= (pil_cnt != CW'(NPILOT));
    end
  end

endmodule
